reg_dump_ctrl: RTL

Register-file read-side sequencer. On a start request it walks the register file's read port from address 0 to NUM_REGS-1, captures each word, and streams (address, data) pairs out over a valid/ready handshake. It is the reader counterpart to the write-side traffic the register file receives, and is used for debug dumps and architectural-state checks at the end of a program. It sits beside reg_file and drives one of its read-address ports.

---
 rtl/reg_dump_ctrl_if.sv | 14 +
 rtl/reg_dump_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/reg_dump_ctrl_if.sv
// Output stream of the register dump sequencer: one (address, data) word per
// valid/ready handshake.
interface reg_dump_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, output out_addr, output out_data, input out_ready);
  modport slave  (input out_valid, input out_addr, input out_data, output out_ready);
endinterface

// File: rtl/reg_dump_ctrl.sv
// Register-file read-side sequencer: walks read addresses 0..NUM_REGS-1 and
// streams each captured word out over a valid/ready handshake.
module reg_dump_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_radd,
  input  logic [DATA_W-1:0] rf_rdata,
  reg_dump_ctrl_if.master   dump,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] ptr_r, ptr_s;
  logic              valid_r, valid_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] data_r, data_s;
  logic              done_r, done_s;
  logic              accept_s;

  // Next-state and next-output decode; abort takes priority over an accept.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    valid_s  = valid_r;
    addr_s   = addr_r;
    data_s   = data_r;
    done_s   = 1'b0;
    accept_s = valid_r & dump.out_ready;
    case (state_r)
      IDLE: begin
        valid_s = 1'b0;
        if (start) begin
          ptr_s   = {ADDR_W{1'b0}};
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (abort) begin
          state_s = IDLE;
          ptr_s   = {ADDR_W{1'b0}};
          valid_s = 1'b0;
        end else begin
          // The only point where the capture register loads.
          data_s  = rf_rdata;
          addr_s  = ptr_r;
          valid_s = 1'b1;
          state_s = HOLD;
        end
      end
      HOLD: begin
        if (abort) begin
          state_s = IDLE;
          ptr_s   = {ADDR_W{1'b0}};
          valid_s = 1'b0;
        end else if (accept_s) begin
          valid_s = 1'b0;
          if (ptr_r == LAST_PTR) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            ptr_s   = ptr_r + ADDR_W'(1);
            state_s = READ;
          end
        end else begin
          state_s = HOLD;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        ptr_s   = {ADDR_W{1'b0}};
        valid_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= {ADDR_W{1'b0}};
      valid_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      valid_r <= valid_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
      done_r  <= done_s;
    end
  end

  // Read address and busy decode straight from state and pointer.
  always_comb begin
    rf_radd = {ADDR_W{1'b0}};
    busy    = 1'b0;
    case (state_r)
      READ, HOLD: begin
        rf_radd = ptr_r;
        busy    = 1'b1;
      end
      IDLE, DONE: begin
        rf_radd = {ADDR_W{1'b0}};
        busy    = 1'b0;
      end
      default: begin
        rf_radd = {ADDR_W{1'b0}};
        busy    = 1'b0;
      end
    endcase
  end

  assign dump.out_valid = valid_r;
  assign dump.out_addr  = addr_r;
  assign dump.out_data  = data_r;
  assign done           = done_r;

endmodule
